// File: rtl/vga_rx_pkg.sv
// rtl/vga_rx_pkg.sv - state encoding and default 640x480@60 timing for the VGA receive monitor
package vga_rx_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } mon_state_e;

   localparam int unsigned RGB_W           = 8;
   localparam int unsigned H_TOTAL_DEF     = 800;
   localparam int unsigned H_ACT_START_DEF = 144;
   localparam int unsigned H_ACTIVE_DEF    = 640;
   localparam int unsigned V_TOTAL_DEF     = 525;
   localparam int unsigned V_ACT_START_DEF = 35;
   localparam int unsigned V_ACTIVE_DEF    = 480;

endpackage

// File: rtl/vga_rx_monitor_if.sv
// rtl/vga_rx_monitor_if.sv - incoming VGA stream from game_top, qualified by the shared pixel enable
interface vga_rx_monitor_if;
   import vga_rx_pkg::*;

   logic             pix_ce;
   logic             hsync;
   logic             vsync;
   logic [RGB_W-1:0] rgb;

   modport master (output pix_ce, hsync, vsync, rgb);
   modport slave  (input  pix_ce, hsync, vsync, rgb);

endinterface

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - samples an active-low sync on pix_ce and flags its falling edge on that same tick
module vga_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic pix_ce_i,
   input  logic sync_i,
   output logic fall_o
);

   logic sync_q;

   // Idle-high reset so a sync already low out of reset still counts as a fall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= 1'b1;
      end else if (pix_ce_i) begin
         sync_q <= sync_i;
      end
   end

   assign fall_o = pix_ce_i & sync_q & ~sync_i;

endmodule

// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - locks to VGA raster timing, emits active pixels, frame checksum and timing errors
module vga_rx_monitor
   import vga_rx_pkg::*;
#(
   parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
   parameter int unsigned H_ACT_START = H_ACT_START_DEF,
   parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
   parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
   parameter int unsigned V_ACT_START = V_ACT_START_DEF,
   parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   vga_rx_monitor_if.slave      vid,
   input  logic                 err_clr,
   output logic                 locked,
   output logic                 pix_valid,
   output logic [9:0]           px,
   output logic [8:0]           py,
   output logic [RGB_W-1:0]     pix_rgb,
   output logic                 frame_done,
   output logic [15:0]          frame_sum,
   output logic [15:0]          frame_cnt,
   output logic                 err_h,
   output logic                 err_v
);

   localparam logic [9:0]  H_LO = 10'(H_ACT_START);
   localparam logic [9:0]  H_HI = 10'(H_ACT_START + H_ACTIVE - 1);
   localparam logic [9:0]  V_LO = 10'(V_ACT_START);
   localparam logic [9:0]  V_HI = 10'(V_ACT_START + V_ACTIVE - 1);
   localparam logic [10:0] H_LEN = 11'(H_TOTAL);
   localparam logic [10:0] V_LEN = 11'(V_TOTAL);

   logic hfall, vfall, herr, verr, active;

   mon_state_e       state_q, state_d;
   logic [9:0]       hcount_q, hcount_d, vcount_q, vcount_d;
   logic [15:0]      sum_q, sum_d, frame_sum_q, frame_sum_d, frame_cnt_q, frame_cnt_d;
   logic             locked_q, locked_d, pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;
   logic             err_h_q, err_h_d, err_v_q, err_v_d;
   logic [9:0]       px_q, px_d;
   logic [8:0]       py_q, py_d;
   logic [RGB_W-1:0] pix_rgb_q, pix_rgb_d;

   vga_sync_edge u_hs_edge (.clk(clk), .rst(rst), .pix_ce_i(vid.pix_ce), .sync_i(vid.hsync), .fall_o(hfall));
   vga_sync_edge u_vs_edge (.clk(clk), .rst(rst), .pix_ce_i(vid.pix_ce), .sync_i(vid.vsync), .fall_o(vfall));

   // Counters hold the position of the previous tick, so length = count + 1 at the next fall.
   assign herr   = hfall && (state_q != SEARCH) && (({1'b0, hcount_q} + 11'd1) != H_LEN);
   assign verr   = vfall && (state_q != SEARCH) && (({1'b0, vcount_q} + 11'd1) != V_LEN);
   assign active = vid.pix_ce && (state_q == LOCKED) &&
                   (hcount_q >= H_LO) && (hcount_q <= H_HI) &&
                   (vcount_q >= V_LO) && (vcount_q <= V_HI);

   always_comb begin
      state_d      = state_q;
      hcount_d     = hcount_q;
      vcount_d     = vcount_q;
      sum_d        = sum_q;
      frame_sum_d  = frame_sum_q;
      frame_cnt_d  = frame_cnt_q;
      px_d         = px_q;
      py_d         = py_q;
      pix_rgb_d    = pix_rgb_q;
      pix_valid_d  = 1'b0;
      frame_done_d = 1'b0;

      if (vid.pix_ce) begin
         hcount_d = hfall ? 10'd0 : ((hcount_q == 10'h3FF) ? hcount_q : hcount_q + 10'd1);
         if (vfall) begin
            vcount_d = 10'd0;
         end else if (hfall) begin
            vcount_d = vcount_q + 10'd1;
         end

         if (active) begin
            pix_valid_d = 1'b1;
            px_d        = hcount_q - H_LO;
            py_d        = 9'(vcount_q - V_LO);
            pix_rgb_d   = vid.rgb;
            sum_d       = sum_q + {{(16-RGB_W){1'b0}}, vid.rgb};
         end

         case (state_q)
            SEARCH: begin
               if (vfall) state_d = MEASURE;
            end
            MEASURE: begin
               if (herr || verr) begin
                  state_d = SEARCH;
               end else if (vfall) begin
                  state_d = LOCKED;
                  sum_d   = 16'd0;
               end
            end
            LOCKED: begin
               if (herr || verr) begin
                  state_d = SEARCH;
               end else if (vfall) begin
                  frame_done_d = 1'b1;
                  frame_sum_d  = sum_d;
                  sum_d        = 16'd0;
                  frame_cnt_d  = frame_cnt_q + 16'd1;
               end
            end
            default: state_d = SEARCH;
         endcase
      end

      locked_d = (state_d == LOCKED);
      // A fresh error outranks a simultaneous clear.
      err_h_d  = herr ? 1'b1 : (err_clr ? 1'b0 : err_h_q);
      err_v_d  = verr ? 1'b1 : (err_clr ? 1'b0 : err_v_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= SEARCH;
         hcount_q     <= 10'd0;
         vcount_q     <= 10'd0;
         sum_q        <= 16'd0;
         frame_sum_q  <= 16'd0;
         frame_cnt_q  <= 16'd0;
         locked_q     <= 1'b0;
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         err_h_q      <= 1'b0;
         err_v_q      <= 1'b0;
         px_q         <= 10'd0;
         py_q         <= 9'd0;
         pix_rgb_q    <= '0;
      end else begin
         state_q      <= state_d;
         hcount_q     <= hcount_d;
         vcount_q     <= vcount_d;
         sum_q        <= sum_d;
         frame_sum_q  <= frame_sum_d;
         frame_cnt_q  <= frame_cnt_d;
         locked_q     <= locked_d;
         pix_valid_q  <= pix_valid_d;
         frame_done_q <= frame_done_d;
         err_h_q      <= err_h_d;
         err_v_q      <= err_v_d;
         px_q         <= px_d;
         py_q         <= py_d;
         pix_rgb_q    <= pix_rgb_d;
      end
   end

   assign locked     = locked_q;
   assign pix_valid  = pix_valid_q;
   assign px         = px_q;
   assign py         = py_q;
   assign pix_rgb    = pix_rgb_q;
   assign frame_done = frame_done_q;
   assign frame_sum  = frame_sum_q;
   assign frame_cnt  = frame_cnt_q;
   assign err_h      = err_h_q;
   assign err_v      = err_v_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - randomized raster stimulus on a reduced timing, checked against a behavioural model
module tb_vga_rx_monitor;

   localparam int HT = 20, HAS = 4, HA = 12, VT = 10, VAS = 2, VA = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        err_clr = 1'b0;
   logic        locked, pix_valid, frame_done, err_h, err_v;
   logic [9:0]  px;
   logic [8:0]  py;
   logic [7:0]  pix_rgb;
   logic [15:0] frame_sum, frame_cnt;

   vga_rx_monitor_if vif ();

   vga_rx_monitor #(
      .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACTIVE(VA)
   ) dut (
      .clk(clk), .rst(rst), .vid(vif), .err_clr(err_clr),
      .locked(locked), .pix_valid(pix_valid), .px(px), .py(py), .pix_rgb(pix_rgb),
      .frame_done(frame_done), .frame_sum(frame_sum), .frame_cnt(frame_cnt),
      .err_h(err_h), .err_v(err_v)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a raster is trusted once two consecutive vsync falls arrive with no error
   // in between; m_clean counts those falls since the last error or reset.
   bit        m_hs, m_vs, m_pv, m_fd, m_errh, m_errv;
   int        m_hc, m_vc, m_clean, m_sum, m_fsum, m_fcnt;
   bit [9:0]  m_px;
   bit [8:0]  m_py;
   bit [7:0]  m_prgb;

   task automatic model_reset();
      m_hs = 1; m_vs = 1; m_pv = 0; m_fd = 0; m_errh = 0; m_errv = 0;
      m_hc = 0; m_vc = 0; m_clean = 0; m_sum = 0; m_fsum = 0; m_fcnt = 0;
      m_px = 0; m_py = 0; m_prgb = 0;
   endtask

   task automatic model_step(input bit ce, input bit hs, input bit vs, input bit [7:0] rgb, input bit clr);
      bit hf, vf, eh, ev, lk;
      m_pv = 0; m_fd = 0; eh = 0; ev = 0;
      if (ce) begin
         hf = m_hs && !hs;
         vf = m_vs && !vs;
         lk = (m_clean >= 2);
         eh = hf && (m_clean >= 1) && (m_hc + 1 != HT);
         ev = vf && (m_clean >= 1) && (m_vc + 1 != VT);
         if (lk && m_hc >= HAS && m_hc < HAS + HA && m_vc >= VAS && m_vc < VAS + VA) begin
            m_pv = 1; m_px = 10'(m_hc - HAS); m_py = 9'(m_vc - VAS); m_prgb = rgb;
            m_sum = (m_sum + rgb) % 65536;
         end
         if (eh || ev) begin
            m_clean = 0;
         end else if (vf) begin
            if (lk) begin
               m_fd = 1; m_fsum = m_sum; m_sum = 0; m_fcnt = (m_fcnt + 1) % 65536;
            end else begin
               if (m_clean == 1) m_sum = 0;
               m_clean++;
            end
         end
         m_hc = hf ? 0 : ((m_hc < 1023) ? m_hc + 1 : 1023);
         m_vc = vf ? 0 : (hf ? (m_vc + 1) % 1024 : m_vc);
         m_hs = hs; m_vs = vs;
      end
      if (eh) m_errh = 1; else if (clr) m_errh = 0;
      if (ev) m_errv = 1; else if (clr) m_errv = 0;
   endtask

   function automatic logic [63:0] model_outs();
      return {m_clean >= 2, m_pv, m_px, m_py, m_prgb, m_fd, 16'(m_fsum), 16'(m_fcnt), m_errh, m_errv};
   endfunction

   function automatic logic [63:0] dut_outs();
      return {locked, pix_valid, px, py, pix_rgb, frame_done, frame_sum, frame_cnt, err_h, err_v};
   endfunction

   task automatic clk_cycle(input bit ce, input bit hs, input bit vs, input bit [7:0] rgb, input bit clr);
      @(negedge clk);
      vif.pix_ce = ce; vif.hsync = hs; vif.vsync = vs; vif.rgb = rgb; err_clr = clr;
      model_step(ce, hs, vs, rgb, clr);
      @(posedge clk);
      #1;
      check_eq("outs", dut_outs(), model_outs());
   endtask

   task automatic idle_cycle();
      clk_cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 0);
   endtask

   task automatic pix_tick(input bit hs, input bit vs, input bit [7:0] rgb, input bit clr);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) idle_cycle();
      clk_cycle(1, hs, vs, rgb, clr);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rst = 0; vif.pix_ce = 1'($urandom_range(0, 1)); vif.hsync = 1'($urandom_range(0, 1));
         vif.vsync = 1'($urandom_range(0, 1)); vif.rgb = 8'($urandom);
         @(posedge clk);
         #1;
         check_eq("rst_outs", dut_outs(), 64'd0);
      end
      @(negedge clk);
      rst = 1; vif.pix_ce = 0;
      model_reset();
   endtask

   // mode: 0 random rgb, 1 constant 0x01, 2 gradient equal to the pixel's px
   task automatic gen_frame(input int nlines, input int short_line, input int mode, input bit clr0, input int rst_line);
      bit [7:0] c;
      for (int l = 0; l < nlines; l++) begin
         if (l == rst_line) do_reset();
         for (int h = 0; h < ((l == short_line) ? HT - 1 : HT); h++) begin
            c = (mode == 1) ? 8'd1 : ((mode == 2) ? 8'(h - 1 - HAS) : 8'($urandom));
            pix_tick(h >= 2, l >= 1, c, clr0 && l == 0 && h == 0);
         end
      end
   endtask

   initial begin
      vif.pix_ce = 0; vif.hsync = 1; vif.vsync = 1; vif.rgb = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset", dut_outs(), 64'd0);
      @(negedge clk);
      rst = 1;

      gen_frame(VT, -1, 1, 0, -1);
      check_eq("measure_unlocked", {63'd0, locked}, 64'd0);
      gen_frame(VT, -1, 1, 0, -1);
      check_eq("locked_rise", {63'd0, locked}, 64'd1);
      gen_frame(VT, -1, 2, 0, -1);
      check_eq("sum_const", {48'd0, frame_sum}, 64'd72);
      check_eq("cnt1", {48'd0, frame_cnt}, 64'd1);
      check_eq("last_px", {54'd0, px}, 64'd11);
      check_eq("last_py", {55'd0, py}, 64'd5);
      check_eq("last_rgb", {56'd0, pix_rgb}, 64'd11);
      gen_frame(VT, -1, 0, 0, -1);
      check_eq("sum_grad", {48'd0, frame_sum}, 64'd396);
      check_eq("cnt2", {48'd0, frame_cnt}, 64'd2);
      gen_frame(VT, -1, 0, 0, -1);
      check_eq("cnt3", {48'd0, frame_cnt}, 64'd3);

      gen_frame(VT, 4, 0, 0, -1);
      check_eq("err_h_set", {63'd0, err_h}, 64'd1);
      check_eq("unlock_h", {63'd0, locked}, 64'd0);
      gen_frame(VT, -1, 0, 0, -1);
      check_eq("no_done_relock", {48'd0, frame_cnt}, 64'd4);
      gen_frame(VT, -1, 0, 0, -1);
      check_eq("relock", {63'd0, locked}, 64'd1);
      check_eq("err_h_sticky", {63'd0, err_h}, 64'd1);
      gen_frame(VT, -1, 0, 0, -1);
      clk_cycle(0, 1, 1, 8'd0, 1);
      check_eq("err_h_clr", {63'd0, err_h}, 64'd0);

      gen_frame(VT - 1, -1, 0, 0, -1);
      gen_frame(VT, -1, 0, 1, -1);
      check_eq("err_v_wins", {63'd0, err_v}, 64'd1);
      check_eq("unlock_v", {63'd0, locked}, 64'd0);
      check_eq("cnt_v", {48'd0, frame_cnt}, 64'd6);

      gen_frame(VT, -1, 0, 0, -1);
      gen_frame(VT, -1, 0, 0, 5);
      check_eq("rst_cnt", {48'd0, frame_cnt}, 64'd0);
      check_eq("rst_unlock", {63'd0, locked}, 64'd0);
      gen_frame(VT, -1, 0, 0, -1);
      check_eq("rst_measure", {63'd0, locked}, 64'd0);
      gen_frame(VT, -1, 0, 0, -1);
      check_eq("rst_relock", {63'd0, locked}, 64'd1);
      gen_frame(VT, -1, 0, 0, -1);
      check_eq("rst_cnt1", {48'd0, frame_cnt}, 64'd1);

      repeat (1000) idle_cycle();
      check_eq("ce_low_cnt", {48'd0, frame_cnt}, 64'd1);
      gen_frame(VT, -1, 0, 0, -1);
      check_eq("resume_cnt", {48'd0, frame_cnt}, 64'd2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
